// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first a-b using one full-subtractor cell; done strobes WIDTH+1 edges after start.
// No backpressure: start is ignored while busy_o is high; results hold until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             ovf_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q, res_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q, busy_q, done_q, borrow_q, ovf_q;
    logic             a_msb_q, b_msb_q;

    logic             bit_d, br_d;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        bit_d = sa_q[0] ^ sb_q[0] ^ br_q;
        br_d  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        res_d = {bit_d, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    res_q <= res_d;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        diff_q   <= res_d;
                        borrow_q <= br_d;
                        // Operand MSBs were saved at capture since sa/sb are shifted out by now.
                        ovf_q    <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ bit_d);
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        sa_q    <= a_i;
                        sb_q    <= b_i;
                        a_msb_q <= a_i[WIDTH-1];
                        b_msb_q <= b_i[WIDTH-1];
                        res_q   <= '0;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;
    assign ovf_o    = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, scoreboard queue, multi-cycle corner cases.
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy_o, done_o, borrow_o, ovf_o;
    logic [W-1:0] diff_o;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [W+1:0] sb_q[$];

    typedef struct {
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
    } vec_t;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .diff_o   (diff_o),
        .borrow_o (borrow_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse pops the oldest expected {diff, borrow, ovf}.
    always @(negedge clk) begin
        if (done_o) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [W+1:0] e;
                e = sb_q.pop_front();
                chk("result", {22'd0, diff_o, borrow_o, ovf_o}, {22'd0, e});
            end
        end
    end

    function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W-1:0] d;
        d = av - bv;
        return {d, av < bv, (av[W-1] ^ bv[W-1]) & (av[W-1] ^ d[W-1])};
    endfunction

    // One operation with latency/busy/hold checks; inject >= 0 raises start during that busy cycle.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W+1:0] exp, input int inject);
        int busy_n, done_c, d0;
        logic [W-1:0] prev;
        logic hold_ok;
        @(negedge clk);
        prev = diff_o;
        d0 = done_cnt;
        a = av; b = bv; start = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        busy_n = 0; done_c = -1; hold_ok = 1'b1;
        for (int c = 0; c < W + 4; c++) begin
            @(negedge clk);
            if (busy_o) begin
                busy_n++;
                if (diff_o !== prev) hold_ok = 1'b0;
            end
            if (done_o && done_c < 0) done_c = c;
            if (c == inject) begin
                a = 8'hFF; b = 8'h01; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("busy_cycles", busy_n, W);
        chk("done_latency", done_c, W);
        chk("diff_hold_in_run", {31'd0, hold_ok}, 32'd1);
        chk("done_count", done_cnt - d0, 32'd1);
    endtask

    vec_t vecs[10];

    initial begin
        int base, c1, c2;
        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
        vecs[8] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};
        vecs[9] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {27'd0, busy_o, done_o, borrow_o, ovf_o, |diff_o}, 32'd0);

        foreach (vecs[i])
            run_op(vecs[i].av, vecs[i].bv, {vecs[i].ed, vecs[i].eb, vecs[i].eo}, -1);

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom); rb = W'($urandom);
            run_op(ra, rb, model(ra, rb), -1);
        end

        // start during the third busy cycle must be ignored
        run_op(8'd10, 8'd4, {8'h06, 1'b0, 1'b0}, 2);

        // reset sampled on edge 4 of a run abandons it
        @(negedge clk);
        a = 8'h55; b = 8'h11; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_run_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_mid_run_diff", {24'd0, diff_o}, 32'd0);
        chk("rst_mid_run_flags", {29'd0, done_o, borrow_o, ovf_o}, 32'd0);
        rst = 1'b0;
        base = done_cnt;
        repeat (W + 4) @(negedge clk);
        chk("no_done_after_rst", done_cnt - base, 32'd0);
        run_op(8'd9, 8'd9, {8'h00, 1'b0, 1'b0}, -1);

        // back-to-back: second start held during the DONE cycle
        @(negedge clk);
        a = 8'h30; b = 8'h08; start = 1'b1;
        sb_q.push_back({8'h28, 1'b0, 1'b0});
        @(posedge clk);
        #1 start = 1'b0;
        c1 = -1;
        for (int c = 0; c < W + 4 && c1 < 0; c++) begin
            @(negedge clk);
            if (done_o) c1 = c;
        end
        chk("b2b_first_done", c1, W);
        a = 8'h10; b = 8'h20; start = 1'b1;
        sb_q.push_back({8'hF0, 1'b1, 1'b0});
        @(posedge clk);
        #1 start = 1'b0;
        c2 = -1;
        for (int c = 1; c < W + 6 && c2 < 0; c++) begin
            @(negedge clk);
            if (done_o) c2 = c;
        end
        chk("b2b_gap", c2, W + 1);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
